// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port ARM register file: sequencer states and
// the datapath's default register width, register count and PC index.
package regfile_pkg;
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W  = 32;
    localparam int RF_NREGS   = 16;
    localparam int RF_PC_IDX  = RF_NREGS - 1;
endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks indices 0..NREGS-2 one per cycle so the
// register array itself can stay resetless.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          busy
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 2);

    rf_state_e     state;
    logic [AW-1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A held reset must not zero anything; the walk starts on the first free edge.
    assign clr_en   = (state == CLEAR) && !reset;
    assign clr_addr = idx;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational read ports, two write ports
// (port 4 wins on collision), optional write bypass and a registered display tap.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NREGS    = RF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int BYPASS   = 0,
    parameter int DISP_REG = 4,
    parameter int DISP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [AW-1:0]     wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [AW-1:0]     wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    input  logic [AW-1:0]     ra3,
    input  logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    output logic [DISP_W-1:0] rdisplay,
    output logic              busy
);
    localparam int            PC   = RF_PC_IDX + (NREGS - RF_NREGS);
    localparam logic [AW-1:0] PC_A = AW'(PC);
    localparam logic [AW-1:0] DISP_A = AW'(DISP_REG);

    // The PC slot is never stored, so the array stops one short of NREGS.
    logic [DATA_W-1:0] rf [NREGS-1];

    logic          clr_en;
    logic [AW-1:0] clr_addr;
    logic          wr_ok, wr3, wr4;

    regfile_clr_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    assign wr_ok = !busy && !reset;
    assign wr4   = wr_ok && we4 && (wa4 < PC_A);
    assign wr3   = wr_ok && we3 && (wa3 < PC_A) && !(wr4 && (wa4 == wa3));

    always_ff @(posedge clk) begin
        if (clr_en)
            rf[clr_addr] <= '0;
        if (wr3)
            rf[wa3] <= wd3;
        if (wr4)
            rf[wa4] <= wd4;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] a);
        if (a == PC_A)
            return r15;
        if (busy)
            return '0;
        if ((BYPASS != 0) && wr4 && (wa4 == a))
            return wd4;
        if ((BYPASS != 0) && wr3 && (wa3 == a))
            return wd3;
        return rf[a];
    endfunction

    always_comb rd1 = read_port(ra1);
    always_comb rd2 = read_port(ra2);
    always_comb rd3 = read_port(ra3);

    logic [DATA_W-1:0] disp_nxt;
    logic [DISP_W-1:0] disp_p0;

    always_comb begin
        disp_nxt = rf[DISP_REG];
        if (wr3 && (wa3 == DISP_A))
            disp_nxt = wd3;
        if (wr4 && (wa4 == DISP_A))
            disp_nxt = wd4;
    end

    // Display stage: mirrors the post-write register value one edge later.
    always_ff @(posedge clk) begin
        if (reset || busy)
            disp_p0 <= '0;
        else
            disp_p0 <= disp_nxt[DISP_W-1:0];
    end

    assign rdisplay = disp_p0;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the register file.
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        we3, we4;
    logic [3:0]  wa3, wa4, ra1, ra2, ra3;
    logic [31:0] wd3, wd4, r15;
    logic [31:0] rd1, rd2, rd3, rd1b, rd2b, rd3b;
    logic [15:0] disp, dispb;
    logic        busy, busyb;

    logic        we_8   = 1'b0;
    logic [2:0]  wa_8   = 3'd0;
    logic [15:0] wd_8   = 16'h0;
    logic [2:0]  ra1_8  = 3'd7;
    logic [2:0]  ra2_8  = 3'd3;
    logic [2:0]  ra3_8  = 3'd4;
    logic [15:0] r15_8  = 16'h0BAD;
    logic [15:0] rd1_8, rd2_8, rd3_8, disp_8;
    logic        busy_8;

    regfile_mp #(.BYPASS(0)) dut (
        .clk(clk), .reset(reset),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
        .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .rdisplay(disp), .busy(busy)
    );

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .reset(reset),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
        .rd1(rd1b), .rd2(rd2b), .rd3(rd3b),
        .rdisplay(dispb), .busy(busyb)
    );

    regfile_mp #(.DATA_W(16), .NREGS(8)) dut8 (
        .clk(clk), .reset(reset),
        .we3(we_8), .wa3(wa_8), .wd3(wd_8),
        .we4(we_8), .wa4(wa_8), .wd4(wd_8),
        .ra1(ra1_8), .ra2(ra2_8), .ra3(ra3_8), .r15(r15_8),
        .rd1(rd1_8), .rd2(rd2_8), .rd3(rd3_8),
        .rdisplay(disp_8), .busy(busy_8)
    );

    int nchecks = 0;
    int nerr    = 0;
    bit ck_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: clear is a countdown of NREGS-1 free cycles after which
    // every register is zero; writes apply port 3 then port 4, so port 4 wins.
    logic [31:0] mrf [15];
    logic [15:0] mdisp = 16'h0;
    int          mleft  = 15;
    int          m8left = 7;

    always @(posedge clk) begin
        if (reset) begin
            mleft <= 15;
            mdisp <= 16'h0;
        end else if (mleft != 0) begin
            mleft <= mleft - 1;
            mdisp <= 16'h0;
            if (mleft == 1)
                for (int i = 0; i < 15; i++) mrf[i] <= 32'h0;
        end else begin
            if (we3 && wa3 != 4'd15) mrf[wa3] <= wd3;
            if (we4 && wa4 != 4'd15) mrf[wa4] <= wd4;
            if (we4 && wa4 == 4'd4)      mdisp <= wd4[15:0];
            else if (we3 && wa3 == 4'd4) mdisp <= wd3[15:0];
            else                         mdisp <= mrf[4][15:0];
        end
        if (reset)            m8left <= 7;
        else if (m8left != 0) m8left <= m8left - 1;
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
        if (a == 4'd15) return r15;
        if (mleft != 0) return 32'h0;
        if (byp && !reset) begin
            if (we4 && wa4 == a) return wd4;
            if (we3 && wa3 == a) return wd3;
        end
        return mrf[a];
    endfunction

    always @(negedge clk) begin
        if (ck_en) begin
            chk("busy",       {31'b0, busy},  {31'b0, mleft != 0});
            chk("busy_b",     {31'b0, busyb}, {31'b0, mleft != 0});
            chk("rd1",        rd1,  exp_rd(ra1, 1'b0));
            chk("rd2",        rd2,  exp_rd(ra2, 1'b0));
            chk("rd3",        rd3,  exp_rd(ra3, 1'b0));
            chk("rd1_byp",    rd1b, exp_rd(ra1, 1'b1));
            chk("rd2_byp",    rd2b, exp_rd(ra2, 1'b1));
            chk("rd3_byp",    rd3b, exp_rd(ra3, 1'b1));
            chk("rdisplay",   {16'h0, disp},  {16'h0, mdisp});
            chk("rdisplay_b", {16'h0, dispb}, {16'h0, mdisp});
            chk("busy_8",     {31'b0, busy_8}, {31'b0, m8left != 0});
            chk("rd1_8_pc",   {16'h0, rd1_8},  {16'h0, r15_8});
            chk("rd2_8",      {16'h0, rd2_8},  32'h0);
            chk("disp_8",     {16'h0, disp_8}, 32'h0);
        end
    end

    initial begin
        int n, n8;
        reset = 1'b1;
        we3 = 1'b0; we4 = 1'b0;
        wa3 = 4'd0; wa4 = 4'd0; wd3 = 32'h0; wd4 = 32'h0;
        ra1 = 4'd0; ra2 = 4'd0; ra3 = 4'd0; r15 = 32'h0;

        @(posedge clk); #1 ck_en = 1'b1;
        chk("reset_busy", {31'b0, busy}, 32'h1);
        chk("reset_disp", {16'h0, disp}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; ra1 = 4'd3; ra2 = 4'd15; r15 = 32'h108;

        n = 0; n8 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("clr_rd_r3",  rd1, 32'h0);
                chk("clr_rd_pc",  rd2, 32'h108);
            end
            if (busy_8) n8++;
            if (!busy) break;
            n++;
        end
        chk("clr_cycles",   n,  32'd15);
        chk("clr_cycles_8", n8, 32'd7);
        chk("pc_8", {16'h0, rd1_8}, 32'h0BAD);

        for (int a = 0; a < 15; a++) begin
            @(posedge clk); #1 ra1 = 4'(a);
            @(negedge clk); chk("post_clr_zero", rd1, 32'h0);
        end

        @(posedge clk); #1
        we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hDEADBEEF;
        we4 = 1'b1; wa4 = 4'd5; wd4 = 32'h12345678;
        @(posedge clk); #1 we3 = 1'b0; we4 = 1'b0; ra1 = 4'd2; ra2 = 4'd5;
        @(negedge clk);
        chk("dual_wr_r2", rd1, 32'hDEADBEEF);
        chk("dual_wr_r5", rd2, 32'h12345678);

        @(posedge clk); #1
        we3 = 1'b1; we4 = 1'b1; wa3 = 4'd7; wa4 = 4'd7; wd3 = 32'h1; wd4 = 32'h2;
        @(posedge clk); #1
        we4 = 1'b0; wa3 = 4'd15; wd3 = 32'hFFFF_FFFF; ra1 = 4'd7;
        @(negedge clk); chk("collision_r7", rd1, 32'h2);
        @(posedge clk); #1 we3 = 1'b0; ra1 = 4'd15; r15 = 32'h108;
        @(negedge clk); chk("pc_write_dropped", rd1, 32'h108);

        @(posedge clk); #1 we3 = 1'b1; wa3 = 4'd4; wd3 = 32'hABCD; ra3 = 4'd4;
        @(negedge clk);
        chk("bypass_rd3",    rd3b, 32'hABCD);
        chk("nobypass_rd3",  rd3,  32'h0);
        chk("disp_before",   {16'h0, disp}, 32'h0);
        @(posedge clk); #1 we3 = 1'b0;
        @(negedge clk);
        chk("disp_after",    {16'h0, disp},  32'hABCD);
        chk("disp_after_b",  {16'h0, dispb}, 32'hABCD);

        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1; we3 = 1'b1; wa3 = 4'd1; wd3 = 32'h55;
        @(posedge clk); #1 reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        #1 we3 = 1'b0;
        chk("reclr_cycles", n, 32'd15);
        @(posedge clk); #1 ra1 = 4'd1;
        @(negedge clk); chk("busy_write_ignored", rd1, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1
            reset = ($urandom_range(0, 149) == 0);
            we3 = $urandom_range(0, 1);
            we4 = $urandom_range(0, 1);
            wa3 = 4'($urandom_range(0, 15));
            wa4 = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
            wd3 = $urandom;
            wd4 = $urandom;
            r15 = $urandom;
            ra1 = 4'($urandom_range(0, 15));
            ra2 = ($urandom_range(0, 1) == 0) ? wa3 : 4'($urandom_range(0, 15));
            ra3 = ($urandom_range(0, 1) == 0) ? wa4 : 4'($urandom_range(0, 15));
        end

        @(posedge clk); #1 reset = 1'b0; we3 = 1'b0; we4 = 1'b0;
        @(negedge clk);
        #1 ck_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the multi-cycle ARM datapath. It replaces the single-write-port register file with:
- three combinational read ports (Rn, Rm, Rs/Ra for MLA/UMLAL);
- two independent write ports, so long multiplies write RdLo and RdHi in one cycle;
- an optional same-cycle write-to-read bypass;
- a post-reset clear sequencer, so the array stays resetless (distributed RAM);
- a registered display tap feeding the Basys3 visualizer.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 16, architectural register count; index NREGS-1 is the PC and is never stored
- AW, $clog2(NREGS), address width
- BYPASS, 0, 1 = a read of an address being written this cycle returns the write data
- DISP_REG, 4, register mirrored on rdisplay
- DISP_W, 16, display width (low bits of DISP_REG)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- we3  in  1  write enable, port 3 (Rd / RdLo)
- wa3  in  AW  write address, port 3
- wd3  in  DATA_W  write data, port 3
- we4  in  1  write enable, port 4 (RdHi / Ra)
- wa4  in  AW  write address, port 4
- wd4  in  DATA_W  write data, port 4
- ra1, ra2, ra3  in  AW each  read addresses
- r15  in  DATA_W  PC+8, returned for reads of address NREGS-1
- rd1, rd2, rd3  out  DATA_W each  read data, combinational
- rdisplay  out  DISP_W  registered copy of rf[DISP_REG][DISP_W-1:0]
- busy  out  1  high while the clear sequencer runs; the controller must hold fetch

## Operation
- State machine, two states:
  - CLEAR: entered from any state whenever reset is high; the clear index is set to 0.
  - CLEAR → READY: after index NREGS-2 has been zeroed.
  - READY: stays in READY until the next reset.
- CLEAR behaviour:
  - With reset low, one register is zeroed per cycle, at the current index; the index then increments.
  - With reset high, nothing is written and the index stays at 0.
  - we3/we4 are ignored.
- Reads:
  - Address NREGS-1 returns r15 in all states.
  - Any other address returns 0 while busy=1, otherwise rf[addr].
- Writes (READY only):
  - A write to address NREGS-1 is dropped on either port.
  - we3 and we4 to different addresses: both write.
  - Same address: port 4 wins and the port 3 data is discarded.
- Bypass:
  - BYPASS=0: reads see pre-edge contents.
  - BYPASS=1: a read of a non-PC address matching an active write port returns that port's wd, with port 4 priority. Bypass is inactive while busy.
- rdisplay:
  - Loads from the post-write value of DISP_REG at each edge, i.e. it reflects a write one cycle later.
  - Cleared to 0 in CLEAR.
- Reset mid-operation: reasserting reset in READY or mid-CLEAR restarts the sequence from index 0. Registers not yet re-zeroed keep their stale values internally, but reads return 0 until busy falls.

## Timing
Reset values:
- busy = 1, rdisplay = 0.
- rd1..rd3 = 0 for non-PC addresses and r15 for the PC address while busy.

Clear latency:
- Reset deasserted before edge E0; registers 0..NREGS-2 are zeroed at edges E0..E(NREGS-2).
- busy falls after edge E(NREGS-2): 15 cycles at NREGS=16.
- The first write is accepted at edge E(NREGS-1).

Write/read latency:
- Write-to-read: 1 edge, or 0 with BYPASS=1.
- Write-to-rdisplay: 1 edge.

## Structure
- Shared package `regfile_pkg` holds:
  - the state enum (CLEAR, READY);
  - the localparam for the PC index (NREGS-1);
  - the default DATA_W/NREGS values used by the datapath.
- One sub-module, `regfile_clr_seq`: state register, clear index counter and busy; outputs clr_en and clr_addr.
- The array, write arbitration, the three read muxes and the display register live in the top level.

## Test plan
1. Reset held 3 cycles, then released: busy = 1 for exactly 15 cycles. During that window ra1=3 returns 0 and ra2=15 with r15=0x108 returns 0x108. Afterwards every register reads 0.
2. READY, we3=1 wa3=2 wd3=0xDEADBEEF and we4=1 wa4=5 wd4=0x12345678 in one cycle: next cycle ra1=2 returns 0xDEADBEEF and ra2=5 returns 0x12345678.
3. Collision: wa3=wa4=7, wd3=0x1, wd4=0x2 → r7 reads 0x2. A write to 15 with wd3=0xFFFF_FFFF leaves ra1=15 returning r15.
4. BYPASS=1: write wa3=4 wd3=0xABCD with ra3=4 in the same cycle → rd3=0xABCD combinationally. rdisplay becomes 0xABCD one edge later. With BYPASS=0, rd3 shows the old value that cycle.
5. Reset reasserted for 1 cycle mid-clear (index 6) → busy stays high 15 more cycles. A write attempted while busy (wa3=1, wd3=0x55) is ignored and r1 reads 0 after clear.
6. Parameter sweep DATA_W=16, NREGS=8: clear takes 7 cycles, and address 7 returns r15.
